// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate command transmitter: command codes,
// shadow register reset values, FSM state type and address/index mapping.
package coord_pkg;

  localparam logic [2:0] CMD_DEMO      = 3'b000;
  localparam logic [2:0] CMD_SET_LEFT  = 3'b001;
  localparam logic [2:0] CMD_SET_TOP   = 3'b010;
  localparam logic [2:0] CMD_NONE      = 3'b011;
  localparam logic [2:0] CMD_INC_COL_X = 3'b100;
  localparam logic [2:0] CMD_INC_COL_Y = 3'b101;
  localparam logic [2:0] CMD_INC_ROW_X = 3'b110;
  localparam logic [2:0] CMD_INC_ROW_Y = 3'b111;

  // Shadow defaults mirror the coordinate controller's own reset view.
  localparam logic [12:0] RST_LEFT      = 13'h1800;
  localparam logic [12:0] RST_TOP       = 13'h102C;
  localparam logic [12:0] RST_INC_COL_X = 13'h008A;
  localparam logic [12:0] RST_INC_COL_Y = 13'h0000;
  localparam logic [12:0] RST_INC_ROW_X = 13'h0000;
  localparam logic [12:0] RST_INC_ROW_Y = 13'h00BB;

  // Packed so that entry i matches dirty bit i.
  localparam logic [5:0][12:0] SHADOW_RST = {RST_INC_ROW_Y, RST_INC_ROW_X,
                                             RST_INC_COL_Y, RST_INC_COL_X,
                                             RST_TOP,       RST_LEFT};

  // Marks an address that does not name a shadow register.
  localparam logic [2:0] IDX_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    SEND       = 2'd2
  } state_t;

  // SET code -> dirty/shadow index; DEMO and NONE codes map to IDX_NONE.
  function automatic logic [2:0] addr_to_idx(input logic [2:0] addr);
    logic [2:0] idx;
    case (addr)
      CMD_SET_LEFT:  idx = 3'd0;
      CMD_SET_TOP:   idx = 3'd1;
      CMD_INC_COL_X: idx = 3'd2;
      CMD_INC_COL_Y: idx = 3'd3;
      CMD_INC_ROW_X: idx = 3'd4;
      CMD_INC_ROW_Y: idx = 3'd5;
      default:       idx = IDX_NONE;
    endcase
    return idx;
  endfunction

  // Dirty/shadow index -> SET code transmitted for it.
  function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = CMD_SET_LEFT;
      3'd1:    code = CMD_SET_TOP;
      3'd2:    code = CMD_INC_COL_X;
      3'd3:    code = CMD_INC_COL_Y;
      3'd4:    code = CMD_INC_ROW_X;
      3'd5:    code = CMD_INC_ROW_Y;
      default: code = CMD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/coord_cmd_prio.sv
// Lowest-set-bit picker over the six dirty flags. Lowest index corresponds to
// the lowest SET code, which gives the ascending transmit order.
module coord_cmd_prio (
  input  logic [5:0] req,
  output logic [2:0] idx,
  output logic [5:0] clr_mask,
  output logic       last,
  output logic       any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

  assign clr_mask = req & (~req + 6'd1);
  assign any      = |req;
  assign last     = any && ((req & ~clr_mask) == '0);

endmodule

// File: rtl/coord_cmd_tx.sv
// Command transmitter for the Mandelbrot coordinate controller. Host writes
// land in six shadow registers; a commit replays the dirty ones as one-cycle
// SET commands during vertical blanking, avoiding next_frame cycles.
// Optional readback port: define COORD_CMD_READBACK_EN.
//
// state      | meaning
// IDLE       | no burst pending; outputs DEMO/NONE
// WAIT_BLANK | burst accepted, waiting for blank && !next_frame
// SEND       | launching dirty registers on consecutive edges
module coord_cmd_tx
  import coord_pkg::*;
#(
  parameter int VALUE_W = 13,
  parameter int CTRL_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [VALUE_W-1:0] wr_data,
  input  logic               commit,
  input  logic               demo_en,
  input  logic               blank,
  input  logic               next_frame,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [VALUE_W-1:0] value,
  output logic               busy
`ifdef COORD_CMD_READBACK_EN
  ,
  input  logic [2:0]         rd_addr,
  output logic [VALUE_W:0]   rd_data
`endif
);

  logic [5:0][VALUE_W-1:0] shadow;
  logic [5:0] dirty;
  logic [5:0] wr_mask;
  logic [5:0] clr_mask;
  logic [2:0] wr_idx;
  logic [2:0] pick_idx;
  logic       pick_last;
  logic       pick_any;
  logic       launch_ok;
  logic       launch;
  state_t     state, state_nx;

  assign wr_idx    = addr_to_idx(wr_addr);
  assign wr_mask   = (wr_en && (wr_idx != IDX_NONE)) ? (6'b1 << wr_idx) : '0;
  assign launch_ok = blank && !next_frame;
  assign busy      = (state != IDLE);

  coord_cmd_prio u_prio (
    .req      (dirty),
    .idx      (pick_idx),
    .clr_mask (clr_mask),
    .last     (pick_last),
    .any      (pick_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and launch decision; a same-edge write keeps the burst alive.
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    case (state)
      IDLE: begin
        if (commit && (dirty != '0)) state_nx = WAIT_BLANK;
      end
      WAIT_BLANK, SEND: begin
        if (launch_ok && pick_any) begin
          launch   = 1'b1;
          state_nx = (pick_last && (wr_mask == '0)) ? IDLE : SEND;
        end else begin
          state_nx = WAIT_BLANK;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shadow storage and dirty tracking; a write wins over a same-edge clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= SHADOW_RST;
      dirty  <= '0;
    end else begin
      dirty <= (dirty & ~(launch ? clr_mask : 6'b0)) | wr_mask;
      if (wr_mask != '0) shadow[wr_idx] <= wr_data;
    end
  end

  // Registered command outputs; the pre-write shadow value is what gets sent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl  <= CMD_NONE;
      value <= '0;
    end else if (launch) begin
      ctrl  <= idx_to_code(pick_idx);
      value <= shadow[pick_idx];
    end else begin
      ctrl  <= demo_en ? CMD_DEMO : CMD_NONE;
      value <= '0;
    end
  end

`ifdef COORD_CMD_READBACK_EN
  logic [2:0] rd_idx;
  assign rd_idx = addr_to_idx(rd_addr);

  // Combinational readback of {dirty, shadow}; non-register addresses read 0.
  always_comb begin
    rd_data = '0;
    if (rd_idx != IDX_NONE) rd_data = {dirty[rd_idx], shadow[rd_idx]};
  end
`endif

endmodule

// File: tb/tb_coord_cmd_tx.sv
// Scoreboard bench for coord_cmd_tx: driver feeds a transaction-level model
// that queues expected commands; a negedge monitor pops and compares.
module tb_coord_cmd_tx;

  localparam logic [2:0] C_DEMO = 3'b000;
  localparam logic [2:0] C_NONE = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [12:0] wr_data;
  logic        commit;
  logic        demo_en;
  logic        blank;
  logic        next_frame;
  logic [2:0]  ctrl;
  logic [12:0] value;
  logic        busy;
`ifdef COORD_CMD_READBACK_EN
  logic [2:0]  rd_addr;
  logic [13:0] rd_data;
`endif

  coord_cmd_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .demo_en    (demo_en),
    .blank      (blank),
    .next_frame (next_frame),
    .ctrl       (ctrl),
    .value      (value),
    .busy       (busy)
`ifdef COORD_CMD_READBACK_EN
    ,
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
  endtask

  // Reference model: shadows and dirty flags indexed directly by SET code.
  typedef struct {
    logic [2:0]  c;
    logic [12:0] v;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  logic [12:0] m_sh[8];
  bit          m_dirty[8];
  bit          m_busy;
  logic [2:0]  exp_idle;
  bit          exp_busy;
  bit          mon_en = 0;

  function automatic bit is_set_code(input int c);
    return (c >= 1) && (c <= 7) && (c != 3);
  endfunction

  function automatic bit any_dirty();
    for (int c = 0; c < 8; c++) if (m_dirty[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      m_sh[c]    = 13'h0;
      m_dirty[c] = 1'b0;
    end
    m_sh[1] = 13'h1800;
    m_sh[2] = 13'h102C;
    m_sh[4] = 13'h008A;
    m_sh[7] = 13'h00BB;
    m_busy  = 1'b0;
  endfunction

  // Predicts what the upcoming clock edge does with the current inputs.
  task automatic model_step();
    bit had_dirty;
    bit sent;
    exp_t e;
    if (!rst_n) begin
      model_reset();
      q.delete();
      exp_idle = C_NONE;
      exp_busy = 1'b0;
      return;
    end
    had_dirty = any_dirty();
    sent = 1'b0;
    if (m_busy && blank && !next_frame) begin
      for (int c = 1; c < 8; c++) begin
        if (!sent && is_set_code(c) && m_dirty[c]) begin
          e.c = 3'(c);
          e.v = m_sh[c];
          e.cyc = edge_cnt + 1;
          q.push_back(e);
          m_dirty[c] = 1'b0;
          sent = 1'b1;
        end
      end
    end
    if (wr_en && is_set_code(int'(wr_addr))) begin
      m_sh[wr_addr]    = wr_data;
      m_dirty[wr_addr] = 1'b1;
    end
    if (m_busy) begin
      if (!any_dirty()) m_busy = 1'b0;
    end else if (commit && had_dirty) begin
      m_busy = 1'b1;
    end
    exp_idle = demo_en ? C_DEMO : C_NONE;
    exp_busy = m_busy;
  endtask

  // Monitor: every command cycle pops one expectation; other cycles idle code.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (is_set_code(int'(ctrl))) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_cmd", {16'(ctrl), 16'(value)}, 32'h0);
        end else begin
          e = q.pop_front();
          chk(ctrl == e.c && value == e.v && edge_cnt == e.cyc, "cmd",
              {3'b0, ctrl, value, 13'(edge_cnt)}, {3'b0, e.c, e.v, 13'(e.cyc)});
        end
      end else begin
        chk(ctrl == exp_idle && value == 13'h0, "idle_out",
            {16'(ctrl), 16'(value)}, {16'(exp_idle), 16'h0});
      end
      chk(busy == exp_busy, "busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [12:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

`ifdef COORD_CMD_READBACK_EN
  task automatic chk_rd(input logic [2:0] a);
    logic [13:0] exp;
    rd_addr = a;
    #1;
    exp = is_set_code(int'(a)) ? {m_dirty[a], m_sh[a]} : 14'h0;
    chk(rd_data == exp, "readback", 32'(rd_data), 32'(exp));
  endtask
`endif

  initial begin
    logic [2:0] codes[6];
    codes = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    demo_en = 1'b0; blank = 1'b0; next_frame = 1'b0;
`ifdef COORD_CMD_READBACK_EN
    rd_addr = 3'd0;
`endif
    model_reset();
    tick();
    mon_en = 1;
    tick();
    rst_n = 1'b1;
    chk(ctrl == C_NONE, "reset_ctrl", 32'(ctrl), 32'(C_NONE));
    chk(busy == 1'b0, "reset_busy", 32'(busy), 32'h0);
`ifdef COORD_CMD_READBACK_EN
    chk_rd(3'd1);
`endif

    // Demo code appears from the cycle after demo_en is sampled.
    demo_en = 1'b1;
    repeat (2) tick();
    chk(ctrl == C_DEMO, "demo_ctrl", 32'(ctrl), 32'(C_DEMO));
    demo_en = 1'b0;
    tick();

    // Two-register burst in one blanking interval.
    wr(3'd1, 13'h1F00);
    wr(3'd2, 13'h0800);
    do_commit();
    blank = 1'b1;
    repeat (4) tick();
    blank = 1'b0;
    tick();

    // All six, blank drops after two commands, remainder follows next blank.
    for (int i = 0; i < 6; i++) wr(codes[i], 13'($urandom));
    do_commit();
    blank = 1'b1;
    repeat (2) tick();
    blank = 1'b0;
    repeat (3) tick();
    blank = 1'b1;
    repeat (6) tick();
    blank = 1'b0;
    tick();

    // next_frame during blank delays the burst by one cycle.
    wr(3'd4, 13'h0123);
    blank = 1'b1;
    do_commit();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    repeat (3) tick();
    blank = 1'b0;
    tick();

    // Write inc_row_y in the edge it launches: old value, then resend.
    wr(3'd1, 13'h0AAA);
    wr(3'd7, 13'h0077);
    do_commit();
    blank = 1'b1;
    tick();
    wr(3'd7, 13'h00C0);
    repeat (3) tick();
    blank = 1'b0;
    tick();

    // Reset mid-burst, then a commit with nothing dirty.
    wr(3'd2, 13'h0222);
    wr(3'd5, 13'h0555);
    wr(3'd6, 13'h0666);
    do_commit();
    blank = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    blank = 1'b0;
`ifdef COORD_CMD_READBACK_EN
    chk_rd(3'd1);
`endif
    tick();
    blank = 1'b1;
    do_commit();
    repeat (3) tick();
    blank = 1'b0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      rst_n      = ($urandom_range(0, 249) != 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = 3'($urandom);
      wr_data    = 13'($urandom);
      commit     = ($urandom_range(0, 4) == 0);
      next_frame = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) blank = ~blank;
      if ($urandom_range(0, 9) == 0) demo_en = ~demo_en;
      tick();
`ifdef COORD_CMD_READBACK_EN
      chk_rd(3'($urandom));
`endif
    end

    // Drain any burst still pending.
    rst_n = 1'b1; wr_en = 1'b0; commit = 1'b0; next_frame = 1'b0; blank = 1'b1;
    repeat (20) tick();
    chk(q.size() == 0, "drain", 32'(q.size()), 32'h0);
    chk(busy == 1'b0, "final_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coord_cmd_tx.md
Name: coord_cmd_tx

Overview:
- Command transmitter feeding the Mandelbrot coordinate controller's ctrl[2:0]/value[12:0] command port.
- Holds host-written shadow copies of the six view registers: left, top, col-x inc, col-y inc, row-x inc, row-y inc.
- On commit, replays dirty registers as one-cycle SET commands, only during vertical blanking and never in a next_frame cycle.
- When idle with demo enabled, drives the DEMO code continuously.

Parameters:
- VALUE_W, 13, command value width.
- CTRL_W, 3, command code width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  host shadow write strobe
- wr_addr  in  3  target register, encoded as its SET ctrl code (1,2,4,5,6,7)
- wr_data  in  13  shadow value
- commit  in  1  request transmission of dirty shadows
- demo_en  in  1  emit DEMO when not sending
- blank  in  1  vertical blanking active
- next_frame  in  1  frame-start pulse from video timing
- ctrl  out  3  command code to coordinate controller
- value  out  13  command value
- busy  out  1  commit accepted and burst not finished

Behaviour:
- Codes: DEMO=000, SET_LEFT=001, SET_TOP=010, NONE=011, INC_COL_X=100, INC_COL_Y=101, INC_ROW_X=110, INC_ROW_Y=111.
- Shadow reset values (match controller defaults):
  - left=13'h1800
  - top=13'h102C
  - inc_col_x=13'h008A
  - inc_col_y=0
  - inc_row_x=0
  - inc_row_y=13'h00BB
- Reset: dirty[5:0]=0, state IDLE, ctrl=NONE, value=0, busy=0.
- Write: wr_en with a valid wr_addr loads the shadow and sets its dirty bit. wr_addr 0 or 3 is ignored.
- ctrl and value are registered. A command launched at edge N appears on the outputs during cycle N+1 for exactly one cycle.
- Launch condition: blank==1 && next_frame==0, sampled at edge N.
- FSM:
  - IDLE: commit && dirty!=0 -> WAIT_BLANK, busy=1. commit with dirty==0 is ignored.
  - WAIT_BLANK: on launch condition -> SEND, launching the first dirty register in the same edge.
  - SEND: each edge launches the lowest-code dirty register and clears its bit.
    - Launch condition false -> WAIT_BLANK, no launch, remaining bits kept.
    - Last dirty bit launched -> IDLE, busy=0 at the same edge.
- Order is ascending code: 1,2,4,5,6,7, clean entries skipped. There are no gap cycles between commands.
- Non-command cycles: ctrl=DEMO if demo_en else NONE; value holds 0.
- Write to a register in the same edge it launches: the old value is sent, the new value is stored, and the dirty bit stays set. It resends later in the same burst.
- Writes during WAIT_BLANK/SEND join the current burst. commit outside IDLE is ignored.
- Reset mid-burst aborts it: dirty cleared, ctrl=NONE next cycle.
- Integrator guarantee: blank falls at least one cycle before the next_frame that starts active video.

Optional Feature:
- Macro COORD_CMD_READBACK_EN.
- Defined: adds input rd_addr[2:0] and output rd_data[13:0] = {dirty bit, shadow}, combinational. Invalid addresses read 0.
- Undefined: neither port exists; shadows are write-only.

Decomposition:
- Package coord_pkg holds:
  - ctrl code localparams
  - the six shadow reset constants
  - state enum IDLE/WAIT_BLANK/SEND
  - wr_addr-to-dirty-index mapping function
- Sub-module coord_cmd_prio: 6-bit lowest-set-bit picker returning index, one-hot clear mask and a "last" flag.

Test Plan:
- Reset with demo_en=0: ctrl=NONE, busy=0. Then demo_en=1: ctrl=000 from the next cycle.
- Write left=13'h1F00, top=13'h0800, commit, blank=1: ctrl=001/value=1F00 then 010/0800 on consecutive cycles; busy drops after the second launch; then ctrl=NONE.
- Write all six, commit, blank falls after two commands: the remaining four are held with ctrl=NONE. At the next blank they go out in order 4,5,6,7.
- next_frame=1 during blank in the cycle after commit: no command in the following cycle; the burst starts one cycle later.
- Write inc_row_y=13'h00C0 in its launch cycle: old value sent, then 111/00C0 resent before busy falls.
- Assert rst_n=0 mid-burst: ctrl=NONE, busy=0, dirty cleared. commit after reset with no writes -> no commands. With COORD_CMD_READBACK_EN: rd_addr=1 reads {0,13'h1800}.
